apb_rr_master: RTL and testbench
================================

// Module: apb_rr_master
// PURPOSE
//  APB requester-side controller: arbitrates NUM_REQ local requesters round-robin onto one APB bus.
//  Sequences the SETUP/ACCESS phases, waits on pready and enforces a timeout.
//  Returns read data and error to the granted requester.
//  Sits between on-chip agents (DMA, config engine, CPU bridge) and the APB register/memory slave.
// PARAMETERS
//  NUM_REQ        2   number of requesters (2..8)
//  ADDR_W         32  paddr width
//  DATA_W         32  pwdata/prdata width
//  RDATA_LAT      1   cycles after the pready=1 edge at which prdata is valid (0 or 1); slave in this subsystem registers prdata
//  TIMEOUT_CYCLES 16  max ACCESS cycles without pready before abort; 0 = timeout disabled
// PORTS
//  pclk        in   1                  clock
//  preset      in   1                  asynchronous reset, active-high
//  req         in   NUM_REQ            per-requester transfer request, held until own req_done
//  req_write   in   NUM_REQ            1=write, 0=read
//  req_addr    in   NUM_REQ x ADDR_W   per-requester address
//  req_wdata   in   NUM_REQ x DATA_W   per-requester write data
//  req_done    out  NUM_REQ            one-cycle completion pulse, one-hot
//  rsp_rdata   out  DATA_W             read data, valid with req_done; 0 for writes/errors
//  rsp_err     out  1                  pslverr or timeout, valid with req_done
//  psel        out  1                  APB select
//  penable     out  1                  APB enable
//  pwrite      out  1                  APB direction
//  paddr       out  ADDR_W             APB address
//  pwdata      out  DATA_W             APB write data
//  prdata      in   DATA_W             APB read data
//  pready      in   1                  APB ready
//  pslverr     in   1                  APB slave error
// BEHAVIOUR
//  Reset: all outputs 0.
//   FSM=IDLE, RR pointer=0, timeout counter=0.
//   Reset mid-transfer aborts immediately; no req_done is issued.
//  FSM: IDLE -> SETUP -> ACCESS -> [CAPTURE] -> IDLE.
//  IDLE: if any req, grant the first set bit at or after the pointer (wrapping).
//   Latch write/addr/wdata/index; go to SETUP.
//   psel=0 in IDLE.
//  SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata from the latch; -> ACCESS.
//  ACCESS: psel=1, penable=1.
//   APB outputs are stable throughout ACCESS.
//   Counter increments each cycle with pready=0.
//  Completion on pready=1:
//   - Writes, or reads with RDATA_LAT=0: req_done[idx]=1 next cycle.
//     rsp_rdata=prdata for reads; rsp_err=pslverr.
//     -> IDLE.
//   - Reads with RDATA_LAT=1: -> CAPTURE; psel=0, penable=0.
//     In CAPTURE, sample prdata; req_done pulse and rsp_* on the following cycle.
//     pslverr is sampled at the pready edge.
//  Timeout: counter == TIMEOUT_CYCLES with pready=0 -> drop psel/penable.
//   req_done[idx]=1, rsp_err=1, rsp_rdata=0; -> IDLE.
//  Pointer update: idx+1 mod NUM_REQ on every req_done, including error/timeout.
//  Pacing: at least one psel=0 cycle between transfers (no back-to-back SETUP).
//  req drop: req dropped after grant is ignored; the transfer completes and done still pulses.
//   req dropped before grant is never granted.
//  Output timing: req_done, rsp_rdata and rsp_err are registered.
//   rsp_rdata/rsp_err return to 0 the cycle after the pulse.
//  Write data: pwdata=0 during reads.
//  Minimum latency, pready=1 immediately: grant cycle 0, SETUP 1, ACCESS 2, req_done cycle 3 (RDATA_LAT=0) or 4 (read, RDATA_LAT=1).
// STRUCTURE
//  Package apb_ctrl_pkg: state_e {IDLE,SETUP,ACCESS,CAPTURE}, default ADDR_W/DATA_W, req_t struct {write,addr,wdata}.
//  Sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant + index; purely combinational.
//   Pointer register stays in apb_rr_master.
//  Timeout counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
// TESTING (bench slave model: 1 write wait, 2 read waits, RDATA_LAT=1)
//  Single write req[0], addr 0x8, wdata 0xDEADBEEF
//   -> one SETUP then ACCESS held 2 cycles; req_done[0] pulse; rsp_err=0.
//  Read-back req[1], addr 0x8 -> SETUP, 3 ACCESS cycles, CAPTURE.
//   req_done[1] with rsp_rdata=0xDEADBEEF.
//  req=2'b11 continuous, pointer=0 -> grants alternate 0,1,0,1.
//   One idle psel=0 cycle between each transfer.
//  Slave holds pready=0, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles psel drops.
//   req_done pulses with rsp_err=1, rsp_rdata=0.
//  pslverr=1 with pready on a write -> req_done with rsp_err=1; pointer still advances.
//  preset asserted during ACCESS -> psel/penable/req_done 0 immediately.
//   After release, first req is granted from pointer 0.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the round-robin APB requester controller.
package apb_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  int unsigned     pos;
  logic [IDX_W-1:0] pos_idx;
  logic            found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 32'd0;
    pos_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos     = (32'(ptr) + i) % N;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB requester-side controller: round-robin arbitration of NUM_REQ agents onto one APB bus,
// SETUP/ACCESS sequencing, optional read-data capture cycle and ACCESS timeout.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned RDATA_LAT      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_W-1:0]              paddr,
  output logic [DATA_W-1:0]              pwdata,
  input  logic [DATA_W-1:0]              prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] owner_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_q;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               timeout_hit;

  // The requester being completed still holds req this cycle; keep it out of the next pick.
  assign arb_req     = req & ~req_done;
  assign ptr_nxt     = IDX_W'(rr_next(32'(idx_q), NUM_REQ));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(wait_cnt) + 32'd1) == TIMEOUT_CYCLES);

  rr_arbiter #(
    .N    (NUM_REQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req  (arb_req),
    .ptr  (ptr),
    .grant(arb_grant),
    .idx  (arb_idx)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      ptr       <= '0;
      idx_q     <= '0;
      owner_q   <= '0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            idx_q   <= arb_idx;
            owner_q <= arb_grant;
            pwrite  <= req_write[arb_idx];
            paddr   <= req_addr[arb_idx];
            pwdata  <= req_write[arb_idx] ? req_wdata[arb_idx] : '0;
            psel    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            wait_cnt <= '0;
            if (!pwrite && (RDATA_LAT != 0)) begin
              err_q <= pslverr;
              state <= CAPTURE;
            end else begin
              req_done  <= owner_q;
              rsp_err   <= pslverr;
              rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
              ptr       <= ptr_nxt;
              state     <= IDLE;
            end
          end else if (timeout_hit) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            wait_cnt <= '0;
            req_done <= owner_q;
            rsp_err  <= 1'b1;
            ptr      <= ptr_nxt;
            state    <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          // Registered slave: prdata is valid one cycle after the pready edge.
          req_done  <= owner_q;
          rsp_err   <= err_q;
          rsp_rdata <= err_q ? '0 : prdata;
          ptr       <= ptr_nxt;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: APB slave model (1 write wait, 2 read waits, registered prdata),
// randomized requesters and a transaction-level reference model.
module tb_apb_rr_master;
  import apb_ctrl_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int          TMO     = 16;

  logic                       pclk;
  logic                       preset;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_write;
  logic [NUM_REQ-1:0][AW-1:0] req_addr;
  logic [NUM_REQ-1:0][DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]         req_done;
  logic [DW-1:0]              rsp_rdata;
  logic                       rsp_err;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [AW-1:0]              paddr;
  logic [DW-1:0]              pwdata;
  logic [DW-1:0]              prdata;
  logic                       pready;
  logic                       pslverr;

  apb_rr_master #(
    .NUM_REQ       (NUM_REQ),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .RDATA_LAT     (1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_done (req_done),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  req_t        cur [NUM_REQ];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  bit   inflight;
  int   fl_idx, fl_setup, fl_acc;
  req_t fl_txn;
  bit   fl_to, fl_slverr;
  int   model_ptr;
  bit   prev_psel;

  int          acc_cnt;
  bit          rd_pend, xfer_hang;
  logic [31:0] rd_val;

  bit gen_en, drop_en, rand_err, rand_hang, err_force, hang_force;
  int gen_pct;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [127:0] bus_of(input req_t t);
    return 128'({t.write, t.addr, (t.write ? t.wdata : 32'h0)});
  endfunction

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    cur[i]       = '{write: w, addr: a, wdata: d};
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req[i]       = 1'b1;
  endtask

  // Transaction-level expectations for every completion, grant and APB phase.
  task automatic monitor();
    logic [NUM_REQ-1:0] oh;
    logic               exp_err;
    logic [31:0]        exp_rd;
    int                 p;
    cyc++;
    if (req_done != '0) begin
      check("done_owner", 128'(inflight), 128'd1);
      if (inflight) begin
        oh         = '0;
        oh[fl_idx] = 1'b1;
        exp_err    = fl_to | fl_slverr;
        exp_rd     = 32'h0;
        if (!fl_txn.write && !exp_err && ref_mem.exists(fl_txn.addr)) exp_rd = ref_mem[fl_txn.addr];
        check("done_vec", 128'(req_done), 128'(oh));
        check("rsp_err", 128'(rsp_err), 128'(exp_err));
        check("rsp_rdata", 128'(rsp_rdata), 128'(exp_rd));
        check("latency", 128'(cyc - fl_setup), 128'(fl_to ? TMO + 1 : (fl_txn.write ? 3 : 5)));
        check("access_cycles", 128'(fl_acc), 128'(fl_to ? TMO : (fl_txn.write ? 2 : 3)));
        if (fl_txn.write && !exp_err) ref_mem[fl_txn.addr] = fl_txn.wdata;
        model_ptr = (fl_idx + 1) % NUM_REQ;
        inflight  = 1'b0;
      end
    end else begin
      check("rsp_idle", 128'({rsp_err, rsp_rdata}), 128'd0);
    end
    if (psel && !penable) begin
      check("pacing", 128'(prev_psel), 128'd0);
      check("overlap", 128'(inflight), 128'd0);
      check("grant_req", 128'(req != '0), 128'd1);
      p = rr_pick(req, model_ptr);
      if (p >= 0) begin
        check("grant_bus", 128'({pwrite, paddr, pwdata}), bus_of(cur[p]));
        inflight  = 1'b1;
        fl_idx    = p;
        fl_txn    = cur[p];
        fl_setup  = cyc;
        fl_acc    = 0;
        fl_to     = 1'b0;
        fl_slverr = 1'b0;
      end
    end
    if (psel && penable) begin
      fl_acc++;
      check("access_owner", 128'(inflight), 128'd1);
      if (inflight) check("access_stable", 128'({pwrite, paddr, pwdata}), bus_of(fl_txn));
    end
    prev_psel = psel;
  endtask

  // Slave: pready after 1 (write) / 2 (read) wait states, prdata one cycle after pready.
  task automatic slave();
    pready  = 1'b0;
    pslverr = 1'($urandom);
    prdata  = $urandom;
    if (rd_pend) begin
      prdata  = rd_val;
      rd_pend = 1'b0;
    end
    if (psel && penable) begin
      acc_cnt++;
      if (acc_cnt == 1) begin
        xfer_hang = hang_force || (rand_hang && $urandom_range(0, 9) == 0);
        fl_to     = xfer_hang;
      end
      if (!xfer_hang && acc_cnt == (pwrite ? 2 : 3)) begin
        pready    = 1'b1;
        pslverr   = err_force || (rand_err && $urandom_range(0, 5) == 0);
        fl_slverr = pslverr;
        if (pwrite && !pslverr) slv_mem[paddr] = pwdata;
        if (!pwrite) begin
          rd_pend = 1'b1;
          rd_val  = slv_mem.exists(paddr) ? slv_mem[paddr] : 32'h0;
        end
      end
    end else begin
      acc_cnt = 0;
    end
  endtask

  task automatic requesters();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_done[i]) req[i] = 1'b0;
      else if (!req[i] && gen_en && !(inflight && fl_idx == i) && $urandom_range(0, 99) < 32'(gen_pct))
        issue(i, 1'($urandom), 32'($urandom_range(0, 7) * 4), $urandom);
      else if (req[i] && drop_en && $urandom_range(0, 49) == 0) req[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge pclk);
    monitor();
    slave();
    requesters();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((req != '0 || inflight) && k < budget) begin
      step();
      k++;
    end
    check("drain", 128'(req != '0 || inflight), 128'd0);
    step();
  endtask

  task automatic clear_model();
    req       = '0;
    inflight  = 1'b0;
    model_ptr = 0;
    prev_psel = 1'b0;
    acc_cnt   = 0;
    rd_pend   = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
  endtask

  initial begin
    int k;
    preset = 1'b1;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    prdata = '0;
    gen_en = 0; drop_en = 0; rand_err = 0; rand_hang = 0; err_force = 0; hang_force = 0;
    gen_pct = 0;
    xfer_hang = 1'b0;
    rd_val = '0;
    clear_model();
    repeat (3) @(negedge pclk);
    check("reset_outputs",
          128'({psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_err}), 128'd0);
    preset = 1'b0;

    issue(0, 1'b1, 32'h8, 32'hDEADBEEF);
    drain(60);
    issue(1, 1'b0, 32'h8, 32'h0);
    drain(60);

    gen_en = 1; gen_pct = 100;
    repeat (40) step();
    gen_en = 0;
    drain(60);

    hang_force = 1;
    issue(0, 1'b1, 32'h10, 32'h1234);
    drain(60);
    issue(1, 1'b0, 32'h8, 32'h0);
    drain(60);
    hang_force = 0;

    err_force = 1;
    issue(0, 1'b1, 32'h8, 32'h5555);
    drain(60);
    err_force = 0;
    issue(0, 1'b0, 32'h8, 32'h0);
    issue(1, 1'b0, 32'h8, 32'h0);
    drain(60);

    issue(0, 1'b1, 32'h20, 32'h77);
    k = 0;
    while (!(psel && penable) && k < 20) begin
      step();
      k++;
    end
    check("reach_access", 128'(psel && penable), 128'd1);
    preset = 1'b1;
    #1;
    check("reset_mid", 128'({psel, penable, req_done}), 128'd0);
    clear_model();
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    issue(0, 1'b0, 32'h20, 32'h0);
    issue(1, 1'b0, 32'h8, 32'h0);
    drain(60);

    gen_en = 1; gen_pct = 30; drop_en = 1; rand_err = 1; rand_hang = 1;
    repeat (3000) step();
    gen_en = 0; drop_en = 0; rand_err = 0; rand_hang = 0;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
